stopwatch_ctrl: RTL and testbench
=================================

// Module: stopwatch_ctrl
// PURPOSE
//  Control FSM for the stopwatch. Takes the 4 debounced button levels and turns them into
//  timer control: count enable, clear pulse, lap-capture pulse and display select.
//  Sits between the debounce block and the time counter / lap register / display mux.
//  Contains rising-edge detection, the run/pause/lap state machine and a long-press
//  qualifier on clear.
// PARAMETERS
//  HOLD_CYCLES  4  consecutive cycles btn[2] must be high before clear fires (>=1)
// PORTS
//  clock      in   1  system clock; all logic on posedge
//  reset      in   1  synchronous, active-high reset
//  btn        in   4  debounced levels: [0]=start/stop [1]=lap [2]=clear [3]=lap release
//  cnt_en     out  1  time counter enable (level)
//  cnt_clr    out  1  time counter clear, 1-cycle pulse
//  lap_load   out  1  capture live time into lap register, 1-cycle pulse
//  disp_sel   out  1  0=live time, 1=lap register
//  state      out  2  IDLE=00 RUN=01 PAUSE=10 LAP=11
// BEHAVIOUR
//  - Reset (sampled at posedge while reset=1): state=IDLE; cnt_en=cnt_clr=lap_load=disp_sel=0.
//    btn_q=4'b1111 so a button held through reset needs release+press. hold_cnt=0.
//  - Edge detect: btn_q<=btn each cycle; rise=btn & ~btn_q.
//  - Latency: rise seen in cycle n -> state/outputs registered, valid in cycle n+1.
//  - Per-cycle priority: clear-fire > start/stop > lap > lap release. At most 1 transition/cycle.
//  - IDLE:  rise[0] -> RUN. rise[1], rise[3] ignored.
//  - RUN:   rise[0] -> PAUSE. Else rise[1] -> LAP with lap_load=1.
//  - LAP:   rise[0] -> PAUSE. Else rise[1] -> stay LAP with lap_load=1 (new split).
//           Else rise[3] -> RUN.
//  - PAUSE: rise[0] -> RUN. rise[1], rise[3] ignored.
//  - Clear qualifier, active only in IDLE or PAUSE:
//    - hold_cnt increments while btn[2]=1 and saturates at HOLD_CYCLES.
//    - hold_cnt is zeroed when btn[2]=0 or the state is RUN/LAP.
//    - Fire when hold_cnt reaches HOLD_CYCLES (that clock): cnt_clr=1 for exactly one cycle,
//      next state=IDLE. The fire overrides a simultaneous rise[0].
//    - Only one fire per press (saturation). btn[2] in RUN/LAP has no effect.
//    - A press begun in RUN does not count until the state is PAUSE.
//  - Outputs: cnt_en=1 iff next state in {RUN,LAP}. disp_sel=1 iff next state=LAP.
//    lap_load and cnt_clr are 0 unless pulsed as above. All outputs registered.
//  - Simultaneous rise[0]&rise[1] in RUN/LAP: PAUSE, no lap_load.
//  - Reset mid-operation (any state, mid-hold): same as power-on reset; pulses drop next cycle.
//  - Width: hold_cnt is $clog2(HOLD_CYCLES+1) bits. No other arithmetic.
// TESTING
//  1. Reset with btn=4'b0001 held, release, press btn[0] -> no RUN until after release;
//     then state=01, cnt_en=1 one cycle after the press is sampled.
//  2. RUN, press btn[1] twice -> lap_load single-cycle pulse each press;
//     state=11, disp_sel=1, cnt_en stays 1. Then btn[3] -> state=01, disp_sel=0.
//  3. PAUSE, btn[2] high 3 cycles then low (HOLD_CYCLES=4) -> no cnt_clr.
//     Held 10 cycles -> exactly one cnt_clr pulse, state=00.
//  4. RUN, btn[0]&btn[1] rise same cycle -> state=10, cnt_en=0, lap_load never 1.
//     btn[2] held 10 cycles in RUN -> no cnt_clr.
//  5. PAUSE, clear reaching HOLD_CYCLES in same cycle as btn[0] rise -> cnt_clr=1, state=00, not RUN.
//  6. Assert reset during LAP with btn[2] held -> next cycle all outputs 0, state=00, hold_cnt=0.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detection, run/pause/lap state machine and
// a long-press qualifier that turns a held clear button into one clear pulse.
module stopwatch_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] btn,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_sel,
    output logic [1:0] state
);

    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [3:0]    btn_q, btn_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic          cnt_en_q, cnt_en_d;
    logic          cnt_clr_q, cnt_clr_d;
    logic          lap_load_q, lap_load_d;
    logic          disp_sel_q, disp_sel_d;

    logic [3:0]    rise;
    logic          clr_armed;
    logic          clr_fire;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            btn_q      <= 4'b1111;
            hold_cnt_q <= '0;
            cnt_en_q   <= 1'b0;
            cnt_clr_q  <= 1'b0;
            lap_load_q <= 1'b0;
            disp_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            btn_q      <= btn_d;
            hold_cnt_q <= hold_cnt_d;
            cnt_en_q   <= cnt_en_d;
            cnt_clr_q  <= cnt_clr_d;
            lap_load_q <= lap_load_d;
            disp_sel_q <= disp_sel_d;
        end
    end

    // Next-state, long-press counter and registered output values.
    always_comb begin
        btn_d      = btn;
        rise       = btn & ~btn_q;
        state_d    = state_q;
        hold_cnt_d = '0;
        lap_load_d = 1'b0;
        clr_armed  = (state_q == ST_IDLE) || (state_q == ST_PAUSE);
        clr_fire   = 1'b0;

        // Counter saturates so a single long press fires only once.
        if (clr_armed && btn[2]) begin
            if (hold_cnt_q < HW'(HOLD_CYCLES)) begin
                hold_cnt_d = hold_cnt_q + HW'(1);
                clr_fire   = (hold_cnt_q == HW'(HOLD_CYCLES - 1));
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end

        if (clr_fire) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise[0]) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (rise[0]) begin
                        state_d = ST_PAUSE;
                    end else if (rise[1]) begin
                        state_d    = ST_LAP;
                        lap_load_d = 1'b1;
                    end
                end
                ST_LAP: begin
                    if (rise[0]) begin
                        state_d = ST_PAUSE;
                    end else if (rise[1]) begin
                        lap_load_d = 1'b1;
                    end else if (rise[3]) begin
                        state_d = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (rise[0]) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end

        cnt_clr_d  = clr_fire;
        cnt_en_d   = (state_d == ST_RUN) || (state_d == ST_LAP);
        disp_sel_d = (state_d == ST_LAP);
    end

    assign state    = state_q;
    assign cnt_en   = cnt_en_q;
    assign cnt_clr  = cnt_clr_q;
    assign lap_load = lap_load_q;
    assign disp_sel = disp_sel_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios then random button traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_stopwatch_ctrl;

    localparam int unsigned HOLD = 4;

    logic       clock;
    logic       reset;
    logic [3:0] btn;
    logic       cnt_en, cnt_clr, lap_load, disp_sel;
    logic [1:0] state;

    int passed = 0;
    int total  = 0;

    // Behavioural model state
    int         m_st;
    int         m_hold_len;
    logic [3:0] m_prev;
    logic       e_en, e_clr, e_lap, e_disp;

    stopwatch_ctrl #(.HOLD_CYCLES(HOLD)) dut (
        .clock    (clock),
        .reset    (reset),
        .btn      (btn),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .lap_load (lap_load),
        .disp_sel (disp_sel),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Model: states 0 idle, 1 run, 2 pause, 3 lap; hold_len counts consecutive
    // clear-high samples taken while idle/paused, clear fires when it equals HOLD.
    task automatic model(input logic r, input logic [3:0] b);
        logic [3:0] rs;
        int         nst;
        logic       fire, lap;
        if (r) begin
            m_st = 0; m_prev = 4'b1111; m_hold_len = 0;
            e_en = 0; e_clr = 0; e_lap = 0; e_disp = 0;
            return;
        end
        rs     = b & ~m_prev;
        m_prev = b;
        if (b[2] && (m_st == 0 || m_st == 2)) m_hold_len++;
        else m_hold_len = 0;
        fire = (m_hold_len == HOLD);
        lap  = 1'b0;
        nst  = m_st;
        if (fire) nst = 0;
        else if (m_st == 0 || m_st == 2) begin
            if (rs[0]) nst = 1;
        end else begin
            if (rs[0]) nst = 2;
            else if (rs[1]) begin nst = 3; lap = 1'b1; end
            else if (rs[3] && m_st == 3) nst = 1;
        end
        m_st   = nst;
        e_clr  = fire;
        e_lap  = lap;
        e_en   = (m_st == 1 || m_st == 3);
        e_disp = (m_st == 3);
    endtask

    task automatic step(input logic r, input logic [3:0] b);
        @(negedge clock);
        reset = r;
        btn   = b;
        model(r, b);
        @(posedge clock);
        #1;
        check("state",    state,            2'(m_st));
        check("cnt_en",   {1'b0, cnt_en},   {1'b0, e_en});
        check("cnt_clr",  {1'b0, cnt_clr},  {1'b0, e_clr});
        check("lap_load", {1'b0, lap_load}, {1'b0, e_lap});
        check("disp_sel", {1'b0, disp_sel}, {1'b0, e_disp});
    endtask

    task automatic repeat_step(input int n, input logic [3:0] b);
        for (int i = 0; i < n; i++) step(1'b0, b);
    endtask

    initial begin
        logic [3:0] rb;
        reset = 1'b1;
        btn   = 4'b0000;
        m_st = 0; m_hold_len = 0; m_prev = 4'b1111;
        e_en = 0; e_clr = 0; e_lap = 0; e_disp = 0;

        // 1: start held through reset needs a release before it starts
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0001);
        check("t1_reset_state", state, 2'b00);
        repeat_step(2, 4'b0001);
        check("t1_held_no_run", state, 2'b00);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0001);
        check("t1_run", state, 2'b01);
        check("t1_en", {1'b0, cnt_en}, 2'b01);

        // 2: two laps, then lap release
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0010);
        check("t2_lap_pulse", {1'b0, lap_load}, 2'b01);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0010);
        step(1'b0, 4'b0000);
        check("t2_lap_state", state, 2'b11);
        step(1'b0, 4'b1000);
        check("t2_back_run", state, 2'b01);
        check("t2_disp", {1'b0, disp_sel}, 2'b00);

        // 3: short clear press ignored, long press clears once
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        repeat_step(3, 4'b0100);
        step(1'b0, 4'b0000);
        check("t3_short_pause", state, 2'b10);
        repeat_step(10, 4'b0100);
        step(1'b0, 4'b0000);
        check("t3_cleared", state, 2'b00);

        // 4: simultaneous start/lap in run pauses; clear in run ignored
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0011);
        check("t4_pause", state, 2'b10);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        repeat_step(10, 4'b0100);
        check("t4_run_kept", state, 2'b01);

        // 5: clear fire beats start rise in the same cycle
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        repeat_step(3, 4'b0100);
        step(1'b0, 4'b0101);
        check("t5_clr", {1'b0, cnt_clr}, 2'b01);
        check("t5_idle", state, 2'b00);
        step(1'b0, 4'b0000);

        // 6: reset in lap with clear held
        step(1'b0, 4'b0001);
        step(1'b0, 4'b0000);
        step(1'b0, 4'b0010);
        repeat_step(2, 4'b0110);
        step(1'b1, 4'b0110);
        check("t6_state", state, 2'b00);
        repeat_step(6, 4'b0100);
        step(1'b0, 4'b0000);

        // Random traffic; clear toggles rarely so long presses occur
        rb = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            rb[0] = ($urandom_range(0, 3) == 0) ? ~rb[0] : rb[0];
            rb[1] = ($urandom_range(0, 3) == 0) ? ~rb[1] : rb[1];
            rb[3] = ($urandom_range(0, 3) == 0) ? ~rb[3] : rb[3];
            rb[2] = ($urandom_range(0, 7) == 0) ? ~rb[2] : rb[2];
            step(($urandom_range(0, 99) == 0), rb);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
